// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Integrating debouncer for a bank of raw key switches, with an
//               optional press/release event queue (KEY_DEBOUNCE_EVENT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int NUM_KEYS = 61,
    parameter int TICK_DIV = 470,
    parameter int CNT_MAX  = 7
) (
    input  logic                        clk_g_i,
    input  logic                        rst_g_i,
    input  logic [NUM_KEYS-1:0]         keys_raw_i,
    output logic [NUM_KEYS-1:0]         keys_o,
    output logic                        keys_changed_o,
    output logic                        tick_o
`ifdef KEY_DEBOUNCE_EVENT_EN
    ,
    output logic                        evt_valid_o,
    input  logic                        evt_ready_i,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key_o,
    output logic                        evt_press_o,
    output logic                        evt_ovf_o
`endif
);

    localparam int c_cw = $clog2(CNT_MAX + 1);
    localparam int c_tw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cw-1:0] c_cnt_max   = c_cw'(CNT_MAX);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
    localparam logic [c_tw-1:0] c_tick_last = c_tw'(TICK_DIV - 1);
    localparam logic [c_tw-1:0] c_tick_one  = c_tw'(1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_keys;
    logic [NUM_KEYS-1:0] w_keys_nxt;
    logic [c_tw-1:0]     r_tick_cnt;
    logic [c_cw-1:0]     r_integ     [NUM_KEYS];
    logic [c_cw-1:0]     w_integ_nxt [NUM_KEYS];
    logic                r_changed;
    logic                w_tick;

    assign w_tick         = (r_tick_cnt == c_tick_last);
    assign tick_o         = w_tick;
    assign keys_o         = r_keys;
    assign keys_changed_o = r_changed;

    // keys_o follows the post-tick integrator value so it moves in the same
    // cycle the integrator saturates; between the rails it holds (hysteresis).
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_integ_nxt[k] = r_integ[k];
            w_keys_nxt[k]  = r_keys[k];
            if (w_tick) begin
                if (r_sync2[k] && (r_integ[k] != c_cnt_max))
                    w_integ_nxt[k] = r_integ[k] + c_cnt_one;
                else if (!r_sync2[k] && (r_integ[k] != '0))
                    w_integ_nxt[k] = r_integ[k] - c_cnt_one;
            end
            if (w_integ_nxt[k] == c_cnt_max)
                w_keys_nxt[k] = 1'b1;
            else if (w_integ_nxt[k] == '0)
                w_keys_nxt[k] = 1'b0;
        end
    end

    always_ff @(posedge clk_g_i or posedge rst_g_i) begin
        if (rst_g_i) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
            r_keys     <= '0;
            r_changed  <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++)
                r_integ[k] <= '0;
        end else begin
            r_sync1    <= keys_raw_i;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + c_tick_one);
            r_keys     <= w_keys_nxt;
            r_changed  <= |(w_keys_nxt ^ r_keys);
            for (int k = 0; k < NUM_KEYS; k++)
                r_integ[k] <= w_integ_nxt[k];
        end
    end

`ifdef KEY_DEBOUNCE_EVENT_EN
    localparam int c_kw = $clog2(NUM_KEYS);
    localparam logic [NUM_KEYS-1:0] c_bit0 = NUM_KEYS'(1);

    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] w_pend_clr;
    logic [NUM_KEYS-1:0] w_chg;
    logic [c_kw-1:0]     w_sel_idx;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic [c_kw:0]       r_fifo_mem [4];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_count;
    logic                r_ovf;

    always_comb begin
        w_sel_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (r_pend[k])
                w_sel_idx = c_kw'(k);
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_full     = (r_count == 3'd4);
    assign w_pop      = (r_count != 3'd0) && evt_ready_i;
    assign w_push     = (|r_pend) && (!w_full || w_pop);
    assign w_pend_clr = w_push ? (c_bit0 << w_sel_idx) : '0;
    assign w_chg      = w_keys_nxt ^ r_keys;

    always_ff @(posedge clk_g_i or posedge rst_g_i) begin
        if (rst_g_i) begin
            r_pend   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_fifo_mem[i] <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_chg;
            if (|(w_chg & r_pend & ~w_pend_clr))
                r_ovf <= 1'b1;
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {w_sel_idx, r_keys[w_sel_idx]};
                r_wr_ptr             <= r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            if (w_push && !w_pop)
                r_count <= r_count + 3'd1;
            else if (!w_push && w_pop)
                r_count <= r_count - 3'd1;
        end
    end

    assign evt_valid_o = (r_count != 3'd0);
    assign evt_key_o   = r_fifo_mem[r_rd_ptr][c_kw:1];
    assign evt_press_o = r_fifo_mem[r_rd_ptr][0];
    assign evt_ovf_o   = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// tb_key_debounce: randomized scoreboard bench; a behavioural model predicts
// debounced key vectors and events, a monitor pops and compares them.
module tb_key_debounce;

    localparam int NK = 61;
    localparam int TD = 4;
    localparam int CM = 3;
    localparam int KW = $clog2(NK);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] raw = '0;
    logic          ready = 1'b1;
    logic [NK-1:0] keys;
    logic          changed;
    logic          tick;
`ifdef KEY_DEBOUNCE_EVENT_EN
    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic          evt_press;
    logic          evt_ovf;
`endif

    key_debounce #(.NUM_KEYS(NK), .TICK_DIV(TD), .CNT_MAX(CM)) dut (
        .clk_g_i        (clk),
        .rst_g_i        (rst),
        .keys_raw_i     (raw),
        .keys_o         (keys),
        .keys_changed_o (changed),
        .tick_o         (tick)
`ifdef KEY_DEBOUNCE_EVENT_EN
        ,
        .evt_valid_o    (evt_valid),
        .evt_ready_i    (ready),
        .evt_key_o      (evt_key),
        .evt_press_o    (evt_press),
        .evt_ovf_o      (evt_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_changes = 0;
    int cyc = 0;
    int h_cyc[$];
    int h_ev[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [NK-1:0] m_s1, m_s2, m_keys, m_pend;
    int            m_cnt [NK];
    int            m_tick;
    int            m_fifo_n;
    bit            m_ovf;
    logic [NK-1:0] q_keys[$];
    int            q_ev[$];

    always @(posedge clk or posedge rst) begin : model
        logic [NK-1:0] nk;
        bit            pop, push;
        int            idx;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_keys = '0; m_pend = '0;
            m_tick = 0; m_fifo_n = 0; m_ovf = 0;
            for (int k = 0; k < NK; k++) m_cnt[k] = 0;
            q_keys.delete();
            q_ev.delete();
        end else begin
            nk = m_keys;
            if (m_tick == TD - 1) begin
                for (int k = 0; k < NK; k++) begin
                    if (m_s2[k]) m_cnt[k] = (m_cnt[k] < CM) ? m_cnt[k] + 1 : CM;
                    else         m_cnt[k] = (m_cnt[k] > 0)  ? m_cnt[k] - 1 : 0;
                    if (m_cnt[k] == CM)     nk[k] = 1'b1;
                    else if (m_cnt[k] == 0) nk[k] = 1'b0;
                end
            end
`ifdef KEY_DEBOUNCE_EVENT_EN
            pop  = (m_fifo_n > 0) && ready;
            push = (m_pend != '0) && ((m_fifo_n < 4) || pop);
            if (push) begin
                idx = 0;
                while (!m_pend[idx]) idx++;
                q_ev.push_back(idx * 2 + int'(m_keys[idx]));
                m_pend[idx] = 1'b0;
            end
            m_fifo_n = m_fifo_n + int'(push) - int'(pop);
            if (((nk ^ m_keys) & m_pend) != '0) m_ovf = 1'b1;
            m_pend = m_pend | (nk ^ m_keys);
`endif
            if (nk != m_keys) q_keys.push_back(nk);
            m_keys = nk;
            m_s2   = m_s1;
            m_s1   = raw;
            m_tick = (m_tick + 1) % TD;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        int e;
        if (!rst) begin
            check("tick", tick, m_tick == TD - 1);
            check("keys", keys, m_keys);
            if (changed) begin
                n_changes++;
                if (q_keys.size() == 0) check("change_unexpected", changed, 1'b0);
                else check("keys_on_change", keys, q_keys.pop_front());
            end
`ifdef KEY_DEBOUNCE_EVENT_EN
            check("evt_valid", evt_valid, m_fifo_n > 0);
            check("evt_ovf", evt_ovf, m_ovf);
            if (evt_valid && ready) begin
                h_cyc.push_back(cyc);
                h_ev.push_back(int'({evt_key, evt_press}));
                if (q_ev.size() == 0) check("evt_unexpected", evt_valid, 1'b0);
                else begin
                    e = q_ev.pop_front();
                    check("evt_entry", {evt_key, evt_press}, e[KW:0]);
                end
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        h_cyc.delete();
        h_ev.delete();
        n_changes = 0;
    endtask

    task automatic check_events(input string name, input int exp[$]);
        check({name, "_count"}, h_ev.size(), exp.size());
        if (h_ev.size() == exp.size())
            for (int i = 0; i < exp.size(); i++)
                check(name, h_ev[i], exp[i]);
    endtask

    initial begin
        step(3);
        check("rst_keys", keys, '0);
        check("rst_changed", changed, 1'b0);
        check("rst_tick", tick, 1'b0);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check("rst_evt_valid", evt_valid, 1'b0);
        check("rst_evt_ovf", evt_ovf, 1'b0);
        check("rst_evt_key", {evt_key, evt_press}, '0);
`endif

        // key held from reset release: 2 sync cycles + 3 ticks
        raw[5] = 1'b1;
        rst = 1'b0;
        step(11);
        check("press_lat_before", keys[5], 1'b0);
        step(1);
        check("press_lat_at", keys[5], 1'b1);
        check("press_pulse", changed, 1'b1);
        step(1);
        check("press_pulse_width", changed, 1'b0);
        step(20);
        check("press_pulse_count", n_changes, 1);

        // one-cycle glitch timed to land on a tick
        raw = '0;
        restart();
        step(1);
        raw[0] = 1'b1;
        step(1);
        raw[0] = 1'b0;
        step(20);
        check("glitch_ignored", keys[0], 1'b0);
        check("glitch_no_change", n_changes, 0);

        // two keys in the same cycle, consumer ready
        ready = 1'b1;
        restart();
        raw[3] = 1'b1;
        raw[60] = 1'b1;
        step(30);
        check("two_keys", {keys[60], keys[3]}, 2'b11);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check_events("two_evt", '{7, 121});
        if (h_cyc.size() == 2) check("two_evt_consecutive", h_cyc[1] - h_cyc[0], 1);
`endif

        // six keys with consumer stalled
        raw = '0;
        ready = 1'b0;
        restart();
        raw[10] = 1'b1; raw[20] = 1'b1; raw[30] = 1'b1;
        raw[40] = 1'b1; raw[50] = 1'b1; raw[59] = 1'b1;
        step(30);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check("six_valid_stalled", evt_valid, 1'b1);
        check("six_none_taken", h_ev.size(), 0);
        ready = 1'b1;
        step(20);
        check_events("six_evt", '{21, 41, 61, 81, 101, 119});
        check("six_no_ovf", evt_ovf, 1'b0);
`else
        check("six_keys", keys, raw);
`endif

        // overflow: key 7 pending behind a full FIFO, then released
        raw = '0;
        ready = 1'b0;
        restart();
        raw[1] = 1'b1; raw[2] = 1'b1; raw[3] = 1'b1; raw[4] = 1'b1; raw[7] = 1'b1;
        step(30);
        raw[7] = 1'b0;
        step(30);
        check("ovf_key7_released", keys[7], 1'b0);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check("ovf_set", evt_ovf, 1'b1);
        ready = 1'b1;
        step(20);
        check_events("ovf_evt", '{3, 5, 7, 9, 14});
        check("ovf_sticky", evt_ovf, 1'b1);
`endif

        // reset mid-operation with key 2 held
        raw = '0;
        ready = 1'b0;
        restart();
        raw[2] = 1'b1;
        raw[9] = 1'b1;
        step(30);
        check("pre_rst_key2", keys[2], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_keys", keys, '0);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check("async_rst_valid", evt_valid, 1'b0);
`endif
        step(2);
        rst = 1'b0;
        step(11);
        check("rerun_before", keys[2], 1'b0);
        step(1);
        check("rerun_at", keys[2], 1'b1);

        // randomized traffic on the low keys
        raw = '0;
        restart();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) raw[$urandom_range(16, NK - 1)] ^= 1'b1;
            ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        raw = '0;
        ready = 1'b1;
        step(100);
        check("drain_keys", keys, '0);
        check("scoreboard_keys_left", q_keys.size(), 0);
        check("scoreboard_evt_left", q_ev.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
